// File: rtl/h_u_cla12_sub_pipe.sv
// ---------------------------------------------------------------------------
// h_u_cla12_sub_pipe
//   Two-stage pipelined unsigned subtractor: diff = a - b, formed as
//   a + ~b + 1 with carry-lookahead groups. Stage 1 resolves the low SPLIT
//   bits and the group carry; stage 2 resolves the upper bits and the
//   borrow (inverted carry-out). Valid/ready handshakes on both sides.
//
//   Optional build macro: H_U_CLA12_SUB_SAT_EN
//     defined   -> a borrowing result is clamped to {1'b1, 0}
//     undefined -> the difference wraps modulo 2^WIDTH
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active-low
//   in_valid   a/b valid this cycle
//   in_ready   block accepts a/b this cycle (combinational from out_ready)
//   a, b       minuend / subtrahend, unsigned, WIDTH bits
//   out_valid  out holds a result
//   out_ready  consumer takes the result this cycle
//   out        {borrow, difference[WIDTH-1:0]}
// ---------------------------------------------------------------------------
module h_u_cla12_sub_pipe #(
   parameter int WIDTH = 12,
   parameter int SPLIT = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out
);
   localparam int HI = WIDTH - SPLIT;

   // Carry into bit position top+1 in flat lookahead form:
   // g[top] | p[top]g[top-1] | ... | p[top..0]cin
   function automatic logic lookahead(input logic [WIDTH-1:0] p,
                                      input logic [WIDTH-1:0] g,
                                      input logic             cin,
                                      input int               top);
      logic acc;
      logic run;
      acc = 1'b0;
      run = 1'b1;
      for (int j = WIDTH - 1; j >= 0; j--) begin
         if (j <= top) begin
            acc = acc | (run & g[j]);
            run = run & p[j];
         end
      end
      return acc | (run & cin);
   endfunction

   // ---------------- stage 1: low group, cin = 1 ----------------
   logic [SPLIT-1:0] bn_lo;
   logic [SPLIT-1:0] p_lo;
   logic [SPLIT-1:0] g_lo;
   logic [SPLIT-1:0] diff_lo;
   logic [SPLIT:0]   c_lo;

   assign bn_lo   = ~b[SPLIT-1:0];
   assign c_lo[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < SPLIT; gi++) begin : gen_lo
         assign p_lo[gi]     = a[gi] ^ bn_lo[gi];
         assign g_lo[gi]     = a[gi] & bn_lo[gi];
         assign c_lo[gi+1]   = lookahead(WIDTH'(p_lo), WIDTH'(g_lo), 1'b1, gi);
         assign diff_lo[gi]  = p_lo[gi] ^ c_lo[gi];
      end
   endgenerate

   logic             s1_valid_reg,   s1_valid_next;
   logic [SPLIT-1:0] s1_diff_lo_reg, s1_diff_lo_next;
   logic             s1_c_split_reg, s1_c_split_next;
   logic [HI-1:0]    s1_a_hi_reg,    s1_a_hi_next;
   logic [HI-1:0]    s1_bn_hi_reg,   s1_bn_hi_next;

   // ---------------- stage 2: high group, cin = c_split ----------------
   logic [HI-1:0] p_hi;
   logic [HI-1:0] g_hi;
   logic [HI-1:0] diff_hi;
   logic [HI:0]   c_hi;
   logic          borrow;
   logic [WIDTH:0] result;

   assign c_hi[0] = s1_c_split_reg;

   generate
      for (gi = 0; gi < HI; gi++) begin : gen_hi
         assign p_hi[gi]    = s1_a_hi_reg[gi] ^ s1_bn_hi_reg[gi];
         assign g_hi[gi]    = s1_a_hi_reg[gi] & s1_bn_hi_reg[gi];
         assign c_hi[gi+1]  = lookahead(WIDTH'(p_hi), WIDTH'(g_hi), s1_c_split_reg, gi);
         assign diff_hi[gi] = p_hi[gi] ^ c_hi[gi];
      end
   endgenerate

   // No carry out of a + ~b + 1 means b was larger.
   assign borrow = ~c_hi[HI];

`ifdef H_U_CLA12_SUB_SAT_EN
   assign result = borrow ? {1'b1, {WIDTH{1'b0}}} : {1'b0, diff_hi, s1_diff_lo_reg};
`else
   assign result = {borrow, diff_hi, s1_diff_lo_reg};
`endif

   logic           out_valid_reg, out_valid_next;
   logic [WIDTH:0] out_reg,       out_next;

   // ---------------- handshake ----------------
   logic advance1;
   logic advance2;
   logic in_xfer;

   assign advance2 = ~out_valid_reg | out_ready;
   assign advance1 = ~s1_valid_reg | (s1_valid_reg & advance2);
   assign in_ready = advance1;
   assign in_xfer  = in_valid & advance1;

   always_comb begin
      s1_valid_next   = s1_valid_reg;
      s1_diff_lo_next = s1_diff_lo_reg;
      s1_c_split_next = s1_c_split_reg;
      s1_a_hi_next    = s1_a_hi_reg;
      s1_bn_hi_next   = s1_bn_hi_reg;
      out_valid_next  = out_valid_reg;
      out_next        = out_reg;

      if (advance1) begin
         s1_valid_next = in_valid;
      end
      if (in_xfer) begin
         s1_diff_lo_next = diff_lo;
         s1_c_split_next = c_lo[SPLIT];
         s1_a_hi_next    = a[WIDTH-1:SPLIT];
         s1_bn_hi_next   = ~b[WIDTH-1:SPLIT];
      end

      if (advance2) begin
         out_valid_next = s1_valid_reg;
         // Data only moves with a real result so out holds its last value.
         if (s1_valid_reg) begin
            out_next = result;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg   <= 1'b0;
         s1_diff_lo_reg <= '0;
         s1_c_split_reg <= 1'b0;
         s1_a_hi_reg    <= '0;
         s1_bn_hi_reg   <= '0;
         out_valid_reg  <= 1'b0;
         out_reg        <= '0;
      end else begin
         s1_valid_reg   <= s1_valid_next;
         s1_diff_lo_reg <= s1_diff_lo_next;
         s1_c_split_reg <= s1_c_split_next;
         s1_a_hi_reg    <= s1_a_hi_next;
         s1_bn_hi_reg   <= s1_bn_hi_next;
         out_valid_reg  <= out_valid_next;
         out_reg        <= out_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign out       = out_reg;

endmodule

// File: tb/tb_h_u_cla12_sub_pipe.sv
// ---------------------------------------------------------------------------
// tb_h_u_cla12_sub_pipe
//   Directed vector table, backpressured streaming, mid-flight reset and a
//   randomized scoreboard run against the 12-bit pipelined subtractor.
// ---------------------------------------------------------------------------
module tb_h_u_cla12_sub_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] a = '0;
   logic [11:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [12:0] out;

   always #5 clk = ~clk;

   h_u_cla12_sub_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out)
   );

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic [12:0] exp_wrap;
      logic [12:0] exp_sat;
      string       name;
   } vec_t;

   vec_t        vecs[10];
   int          tests = 0;
   int          fails = 0;
   logic [12:0] q[$];
   logic        hold_pending = 1'b0;
   logic [12:0] held_out = '0;

   task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
      end else begin
         $display("ok   %s: 0x%04h", name, act);
      end
   endtask

   function automatic logic [12:0] exp_of(input logic [11:0] x, input logic [11:0] y);
      logic [12:0] r;
      r = {1'b0, x} - {1'b0, y};
`ifdef H_U_CLA12_SUB_SAT_EN
      if (x < y) r = 13'h1000;
`endif
      return r;
   endfunction

   // Single operand through an otherwise empty pipe with out_ready held high.
   task automatic run_one(input logic [11:0] x, input logic [11:0] y,
                          input logic [12:0] req, input string name);
      a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check({name, ".in_ready"}, {12'd0, in_ready}, 13'd1);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      #1;
      check({name, ".valid_c1"}, {12'd0, out_valid}, 13'd0);
      @(posedge clk); @(negedge clk);
      #1;
      check({name, ".valid_c2"}, {12'd0, out_valid}, 13'd1);
      check({name, ".out"}, out, req);
      @(posedge clk); @(negedge clk);
      #1;
      check({name, ".valid_drop"}, {12'd0, out_valid}, 13'd0);
   endtask

   // One cycle of the streaming scoreboard; inputs are already driven.
   task automatic step(output logic in_x, output logic out_x);
      #1;
      check("in_ready", {12'd0, in_ready}, {12'd0, !(q.size() == 2 && !out_ready)});
      if (hold_pending) begin
         check("stall_valid", {12'd0, out_valid}, 13'd1);
         check("stall_out", out, held_out);
      end
      if (q.size() == 0) check("idle_valid", {12'd0, out_valid}, 13'd0);
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      if (out_x) begin
         if (q.size() == 0) begin
            check("stray_result", out, 13'h0000);
            tests++; fails++;
            $display("FAIL stray_result: result 0x%04h with nothing in flight", out);
         end else begin
            check("stream_out", out, q.pop_front());
         end
      end
      hold_pending = out_valid && !out_ready;
      held_out     = out;
      if (in_x) q.push_back(exp_of(a, b));
      @(posedge clk); @(negedge clk);
   endtask

   task automatic drain();
      logic ix, ox;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10 && q.size() > 0; i++) step(ix, ox);
      check("drain_empty", 13'(q.size()), 13'd0);
   endtask

   initial begin
      logic ix, ox;
      int   sent, recv, acc;
      logic [11:0] sa[8];
      logic [11:0] sb[8];

      vecs[0] = '{12'hFFF, 12'h001, 13'h0FFE, 13'h0FFE, "no_borrow"};
      vecs[1] = '{12'h000, 12'h001, 13'h1FFF, 13'h1000, "borrow"};
      vecs[2] = '{12'h040, 12'h001, 13'h003F, 13'h003F, "split_040"};
      vecs[3] = '{12'h800, 12'h7FF, 13'h0001, 13'h0001, "split_800"};
      vecs[4] = '{12'h123, 12'h123, 13'h0000, 13'h0000, "equal"};
      vecs[5] = '{12'h000, 12'hFFF, 13'h1001, 13'h1000, "zero_minus_max"};
      vecs[6] = '{12'hFFF, 12'h000, 13'h0FFF, 13'h0FFF, "max_minus_zero"};
      vecs[7] = '{12'h5A5, 12'h0A5, 13'h0500, 13'h0500, "hi_only"};
      vecs[8] = '{12'h0A5, 12'h5A5, 13'h1B00, 13'h1000, "hi_borrow"};
      vecs[9] = '{12'h03F, 12'h040, 13'h1FFF, 13'h1000, "lo_to_hi_borrow"};

      sa = '{12'h010, 12'hFFF, 12'h000, 12'h800, 12'h123, 12'h7FF, 12'h040, 12'hABC};
      sb = '{12'h001, 12'h001, 12'h001, 12'h7FF, 12'h456, 12'h800, 12'h001, 12'h0BC};

      // Reset state
      @(negedge clk); @(negedge clk);
      #1;
      check("rst.out_valid", {12'd0, out_valid}, 13'd0);
      check("rst.out", out, 13'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst.in_ready", {12'd0, in_ready}, 13'd1);
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 10; i++) begin
`ifdef H_U_CLA12_SUB_SAT_EN
         run_one(vecs[i].a, vecs[i].b, vecs[i].exp_sat, vecs[i].name);
`else
         run_one(vecs[i].a, vecs[i].b, vecs[i].exp_wrap, vecs[i].name);
`endif
      end

      // Streaming, 8 back-to-back pairs, out_ready toggling 1,0,1,0
      sent = 0; recv = 0;
      for (int cyc = 0; cyc < 60 && (sent < 8 || q.size() > 0); cyc++) begin
         out_ready = (cyc % 2 == 0);
         if (sent < 8) begin
            in_valid = 1'b1; a = sa[sent]; b = sb[sent];
         end else begin
            in_valid = 1'b0;
         end
         step(ix, ox);
         if (ix) sent++;
         if (ox) recv++;
      end
      check("stream_sent", 13'(sent), 13'd8);
      check("stream_recv", 13'(recv), 13'd8);
      drain();

      // Reset mid-flight: two operands in, then reset
      in_valid = 1'b1; a = 12'h100; b = 12'h001; out_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      a = 12'h300; b = 12'h002;
      @(posedge clk); @(negedge clk);
      #1;
      check("mid.pre_valid", {12'd0, out_valid}, 13'd1);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid.rst_valid", {12'd0, out_valid}, 13'd0);
      check("mid.rst_out", out, 13'h0000);
      q.delete();
      hold_pending = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check("mid.no_stale", {out_valid, out[11:0]}, 13'h0000);
      end
      run_one(12'h200, 12'h0FF, 13'h0101, "mid.next");

      // Random traffic
      acc = 0;
      for (int cyc = 0; cyc < 40000 && acc < 10000; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a = 12'($urandom);
         b = 12'($urandom);
         if ($urandom_range(0, 15) == 0) b = a;
         step(ix, ox);
         if (ix) acc++;
      end
      check("rand_accepted", 13'(acc), 13'd10000);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
